edge_event_arbiter: RTL
=======================

# edge_event_arbiter

Multi-channel edge-event controller. It detects rising and falling edges on N synchronous input lines and holds one pending event per channel. It shares a single event output port among the channels with round-robin arbitration and a valid/ready handshake. It sits between the per-signal edge logic and a single downstream consumer (interrupt/logger), and flags lost events per channel.

## Interface
- `N`, default 4: number of input channels, 2..16
- `CH_W`, default `$clog2(N)`: channel index width (derived, not overridden)
- `clk`  in  1  rising-edge clock; the only clock
- `rst`  in  1  reset; synchronous, active-high
- `in`  in  N  monitored lines, already synchronous to `clk`
- `en`  in  N  per-channel enable (quasi-static config)
- `ovf_clr`  in  N  per-channel pulse that clears the sticky overflow flag
- `evt_valid`  out  1  output event valid
- `evt_ready`  in  1  consumer accepts the event
- `evt_ch`  out  CH_W  channel index of the event
- `evt_rise`  out  1  1 = rising edge, 0 = falling edge
- `pend`  out  N  per-channel pending-slot occupancy
- `ovf`  out  N  per-channel sticky overflow

## Operation
- **Sampling**
  - Each channel keeps `s0 <= in[i]` and `s1 <= s0`.
  - Edge is detected when `s0 != s1`; type is rise if `s0 == 1`.
- **Reset**
  - `s0` and `s1` both load `in` while `rst` is high, so no spurious edge at release.
  - `pend`, `ovf`, `evt_valid`, `evt_ch`, `evt_rise`, and the round-robin pointer `rr` all reset to 0.
- **Pending slot**
  - One slot per channel holding {valid, rise}.
  - A detected edge with `en[i] = 1` sets the slot if the slot is empty, or if it is being granted this cycle. In that case the new edge replaces the granted one.
  - If the slot is occupied and not granted, the new edge is dropped and `ovf[i]` is set.
- **Enable**
  - `en[i] = 0` suppresses detection and flushes the slot on the next clock.
  - `s0` and `s1` keep tracking `in` while disabled, so re-enabling causes no spurious event.
- **Overflow clear**
  - `ovf_clr[i]` clears `ovf[i]`.
  - A simultaneous new overflow wins: the flag stays 1.
- **Arbitration**
  - Load condition: `!evt_valid || evt_ready`.
  - When the load condition holds, the block grants the first occupied slot searching from index `rr` upward, wrapping modulo N.
  - The granted slot is copied into the output register, then `rr <= grant + 1`, wrapping N-1 to 0.
  - If no slot is occupied, `evt_valid <= 0` when `evt_ready` is high; otherwise the output holds.
- **Handshake**
  - While `evt_valid && !evt_ready`, `evt_valid`, `evt_ch` and `evt_rise` are stable.
  - No grant occurs in that state.

## Timing
- Latency: `in` change sampled at edge E0 → slot set at E1 → `evt_valid` high after E2. That is 2 cycles from the sampling edge to `evt_valid`, with the output idle.
- Throughput: one event per cycle when `evt_ready` is held high.
- A channel toggling every cycle produces one edge per cycle. It needs sustained grants to avoid overflow; with N contending channels it overflows unless it is the only active channel.
- Reset asserted mid-handshake: the output drops on the next edge and the event is lost. No `ovf` is set.
- Status outputs `pend` and `ovf` are registered and update on the clock after the causing event.

## Structure
- **Package `edge_arb_pkg`**
  - Typedef `edge_evt_t` {logic rise; logic [CH_W-1:0] ch}.
  - Constant `EVT_FALL = 1'b0` and `EVT_RISE = 1'b1`.
- **Sub-module `edge_arb_chan`**, one instance per channel:
  - Contains the `s0`/`s1` sampler, the edge detect, the pending slot and the sticky overflow.
  - Ports: `clk`, `rst`, `in`, `en`, `grant`, `ovf_clr` → `pend`, `rise`, `ovf`.
- **Top level**: round-robin grant logic, `rr` pointer and output register.

## Test plan
- **Reset release with `in = 4'b1010`** → no event for 10 cycles; `pend = 0` and `ovf = 0`.
- **Single rise**: `in[2]` 0→1, `evt_ready = 1` → `evt_valid` 2 cycles after the sampling edge with `evt_ch = 2`, `evt_rise = 1`, for exactly one cycle.
- **Simultaneous rises**: `in[0]`, `in[1]` and `in[3]` rise in the same cycle, `rr = 0`, `evt_ready = 1` → events in the order ch0, ch1, ch3 on consecutive cycles. Then a rise on ch0 and ch3 together with `rr = 0` → ch0 first, then ch3.
- **Backpressure**: `evt_ready = 0` for 5 cycles with the ch1 event pending → outputs stable. A second and third edge on ch1 → `ovf[1] = 1` after the third edge, and `pend[1]` keeps the second edge's type. Release `ready` → the ch1 events drain in order of the slot contents.
- **Overflow clear race**: pulse `ovf_clr[1]` in the same cycle as a new ch1 overflow → `ovf[1]` stays 1. Pulse it in an idle cycle → `ovf[1] = 0`.
- **Enable drop**: deassert `en[2]` with `pend[2] = 1` → `pend[2] = 0` next cycle and no ch2 event. Toggle `in[2]` while disabled, then re-enable → no event until the next real edge.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge-event arbiter.
// The channel field is sized for the largest supported channel count (16).
package edge_arb_pkg;

    localparam int EVT_CH_W = 4;

    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

    typedef struct packed {
        logic                rise;
        logic [EVT_CH_W-1:0] ch;
    } edge_evt_t;

endpackage

// File: rtl/edge_arb_chan.sv
// One channel: two-stage sampler, edge detect, single pending slot, sticky overflow.
module edge_arb_chan
    import edge_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic en,
    input  logic grant,
    input  logic ovf_clr,
    output logic pend,
    output logic rise,
    output logic ovf
);

    logic s0_q, s1_q;
    logic pend_q, pend_d;
    logic rise_q, rise_d;
    logic ovf_q, ovf_d;
    logic edge_det;
    logic new_ovf;

    assign edge_det = en && (s0_q != s1_q);

    always_comb begin
        pend_d  = pend_q;
        rise_d  = rise_q;
        new_ovf = 1'b0;
        if (!en) begin
            pend_d = 1'b0;
        end else if (edge_det) begin
            // A slot being granted this cycle is free to take the new edge.
            if (!pend_q || grant) begin
                pend_d = 1'b1;
                rise_d = s0_q ? EVT_RISE : EVT_FALL;
            end else begin
                new_ovf = 1'b1;
            end
        end else if (grant) begin
            pend_d = 1'b0;
        end
        ovf_d = (ovf_q && !ovf_clr) || new_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Preload both stages so releasing reset never looks like an edge.
            s0_q   <= in;
            s1_q   <= in;
            pend_q <= 1'b0;
            rise_q <= EVT_FALL;
            ovf_q  <= 1'b0;
        end else begin
            s0_q   <= in;
            s1_q   <= s0_q;
            pend_q <= pend_d;
            rise_q <= rise_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pend = pend_q;
    assign rise = rise_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// N-channel edge-event controller: per-channel pending slots shared onto one
// valid/ready event port by a round-robin arbiter with a registered output.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CH_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in,
    input  logic [N-1:0]    en,
    input  logic [N-1:0]    ovf_clr,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N-1:0]    pend,
    output logic [N-1:0]    ovf
);

    logic [N-1:0]    rise_w;
    logic [N-1:0]    grant;
    logic            load;
    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W:0]   scan_idx;

    logic            evt_valid_q, evt_valid_d;
    logic [CH_W-1:0] evt_ch_q, evt_ch_d;
    logic            evt_rise_q, evt_rise_d;
    logic [CH_W-1:0] rr_q, rr_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        edge_arb_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .in      (in[gi]),
            .en      (en[gi]),
            .grant   (grant[gi]),
            .ovf_clr (ovf_clr[gi]),
            .pend    (pend[gi]),
            .rise    (rise_w[gi]),
            .ovf     (ovf[gi])
        );
        assign grant[gi] = load && gnt_found && (gnt_idx == CH_W'(gi));
    end

    assign load = !evt_valid_q || evt_ready;

    // First occupied slot at or after rr, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, rr_q} + (CH_W+1)'(k);
            if (scan_idx >= (CH_W+1)'(N)) begin
                scan_idx = scan_idx - (CH_W+1)'(N);
            end
            if (!gnt_found && pend[scan_idx[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        rr_d        = rr_q;
        if (load) begin
            if (gnt_found) begin
                evt_valid_d = 1'b1;
                evt_ch_d    = gnt_idx;
                evt_rise_d  = rise_w[gnt_idx];
                rr_d        = (gnt_idx == CH_W'(N - 1)) ? '0 : gnt_idx + CH_W'(1);
            end else begin
                evt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= EVT_FALL;
            rr_q        <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;

endmodule
